// File: rtl/ibex_prefetch_req_ctrl.sv
// Instruction-side bus master feeding the fetch FIFO: issues word-aligned
// requests, tracks outstanding ones and drops responses made stale by branches.
module ibex_prefetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o
);

    localparam int unsigned CW = $clog2(NUM_REQS + 1);

    logic [CW-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic          pending_q, pending_d;
    logic          branch_pend_q, branch_pend_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   branch_addr_q, branch_addr_d;
    logic [31:0]   addr_sel, tgt;
    logic          req_new, gnt_ok, rv_ok;

    always_comb begin
        tgt          = {addr_i[31:2], 2'b00};
        req_new      = req_i & fifo_ready_i & (cnt_q < CW'(NUM_REQS));
        instr_req_o  = pending_q | req_new;
        addr_sel     = pending_q     ? pend_addr_q   :
                       branch_pend_q ? branch_addr_q : fetch_addr_q;
        instr_addr_o = {addr_sel[31:2], 2'b00};
        gnt_ok       = instr_req_o & instr_gnt_i;
        rv_ok        = instr_rvalid_i & (cnt_q != '0);

        cnt_d        = cnt_q + CW'(gnt_ok) - CW'(rv_ok);
        pending_d    = instr_req_o & ~instr_gnt_i;
        pend_addr_d  = instr_addr_o;

        fetch_addr_d = fetch_addr_q;
        if (gnt_ok) fetch_addr_d = instr_addr_o + 32'd4;
        if (branch_i) fetch_addr_d = tgt;

        // The deferred target is consumed once it is presented as a fresh request
        branch_pend_d = branch_pend_q;
        branch_addr_d = branch_addr_q;
        if (instr_req_o & ~pending_q) branch_pend_d = 1'b0;
        if (branch_i) begin
            branch_pend_d = pending_q | gnt_ok;
            branch_addr_d = tgt;
        end

        // A still-ungranted request at the branch belongs to the old stream too
        dcnt_d = dcnt_q;
        if (branch_i) begin
            dcnt_d = cnt_d + CW'(pending_d);
        end else if (rv_ok && dcnt_q != '0) begin
            dcnt_d = dcnt_q - CW'(1);
        end

        fifo_valid_o = rv_ok & (dcnt_q == '0) & ~branch_i;
        fifo_clear_o = branch_i;
        fifo_addr_o  = addr_i;
        fifo_rdata_o = instr_rdata_i;
        fifo_err_o   = instr_err_i;
        busy_o       = pending_q | (cnt_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            dcnt_q        <= '0;
            pending_q     <= 1'b0;
            branch_pend_q <= 1'b0;
            pend_addr_q   <= '0;
            fetch_addr_q  <= '0;
            branch_addr_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            dcnt_q        <= dcnt_d;
            pending_q     <= pending_d;
            branch_pend_q <= branch_pend_d;
            pend_addr_q   <= pend_addr_d;
            fetch_addr_q  <= fetch_addr_d;
            branch_addr_q <= branch_addr_d;
        end
    end

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// Directed bench: stimulus pushes expected FIFO pushes into a queue,
// a negedge monitor pops and compares whenever fifo_valid_o is high.
module tb_ibex_prefetch_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, br, gnt, rv, err, rdy;
    logic [31:0] baddr, rdata;
    logic        busy, ireq, clr, fvalid, ferr;
    logic [31:0] iaddr, faddr, frdata;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] expq[$];

    always #5 clk = ~clk;

    ibex_prefetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(br),
        .addr_i(baddr), .busy_o(busy), .instr_req_o(ireq),
        .instr_gnt_i(gnt), .instr_addr_o(iaddr),
        .instr_rvalid_i(rv), .instr_rdata_i(rdata), .instr_err_i(err),
        .fifo_clear_o(clr), .fifo_valid_o(fvalid), .fifo_ready_i(rdy),
        .fifo_addr_o(faddr), .fifo_rdata_o(frdata), .fifo_err_o(ferr)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // One clock cycle: drive after the rising edge, return at the falling edge
    task automatic cyc(input logic rq, input logic g, input logic r,
                       input logic push, input logic [31:0] rd = 0,
                       input logic b = 0, input logic [31:0] ba = 0,
                       input logic e = 0, input logic ry = 1);
        @(posedge clk);
        #1;
        req = rq; gnt = g; rv = r; rdata = rd;
        br = b; baddr = ba; err = e; rdy = ry;
        if (push) expq.push_back({e, rd});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && fvalid) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got push %h want none", frdata);
            end else begin
                logic [32:0] e;
                e = expq.pop_front();
                chk("sb_rdata", frdata, e[31:0]);
                chk("sb_err", {31'd0, ferr}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        req = 0; br = 0; gnt = 0; rv = 0; err = 0; rdy = 1;
        baddr = 0; rdata = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        chk("rst_req", {31'd0, ireq}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_valid", {31'd0, fvalid}, 0);

        // branch to 0x80; the branch-cycle request to 0x0 is stale
        cyc(1, 1, 0, 0, 0, 1, 32'h80);
        chk("br_clear", {31'd0, clr}, 1);
        chk("br_faddr", faddr, 32'h80);
        chk("br_oldaddr", iaddr, 32'h0);
        cyc(1, 1, 1, 0, dat(0));
        chk("drop0_valid", {31'd0, fvalid}, 0);
        chk("addr80", iaddr, 32'h80);
        cyc(1, 1, 1, 1, dat(32'h80));
        chk("addr84", iaddr, 32'h84);
        cyc(1, 1, 1, 1, dat(32'h84));
        chk("addr88", iaddr, 32'h88);

        // stalled grant: request and address held while req/ready drop
        cyc(1, 0, 1, 1, dat(32'h88));
        chk("stall0_addr", iaddr, 32'h8C);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall1_req", {31'd0, ireq}, 1);
        chk("stall1_busy", {31'd0, busy}, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall2_req", {31'd0, ireq}, 1);
        chk("stall2_addr", iaddr, 32'h8C);
        cyc(0, 1, 0, 0);
        chk("stall3_addr", iaddr, 32'h8C);
        cyc(0, 0, 1, 1, dat(32'h8C));
        chk("after_stall_req", {31'd0, ireq}, 0);
        cyc(0, 0, 0, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // two outstanding, then branch drops both responses
        cyc(0, 0, 0, 0, 0, 1, 32'h100);
        cyc(1, 1, 0, 0);
        chk("addr100", iaddr, 32'h100);
        cyc(1, 1, 0, 0);
        chk("addr104", iaddr, 32'h104);
        cyc(1, 0, 0, 0);
        chk("cap_req", {31'd0, ireq}, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h202);
        chk("br2_faddr", faddr, 32'h202);
        chk("br2_clear", {31'd0, clr}, 1);
        cyc(0, 0, 1, 0, dat(32'h100));
        chk("drop100", {31'd0, fvalid}, 0);
        cyc(0, 0, 1, 0, dat(32'h104));
        chk("drop104", {31'd0, fvalid}, 0);
        cyc(1, 1, 0, 0);
        chk("addr200", iaddr, 32'h200);
        cyc(0, 0, 1, 1, dat(32'h200));

        // branch while a request is pending ungranted
        cyc(0, 0, 0, 0, 0, 1, 32'h10);
        cyc(1, 0, 0, 0);
        chk("pend_addr10", iaddr, 32'h10);
        cyc(1, 0, 0, 0, 0, 1, 32'h40);
        chk("pend_br_addr", iaddr, 32'h10);
        cyc(1, 1, 0, 0);
        chk("pend_gnt_addr", iaddr, 32'h10);
        cyc(1, 1, 1, 0, dat(32'h10));
        chk("addr40", iaddr, 32'h40);
        chk("drop10", {31'd0, fvalid}, 0);
        cyc(0, 0, 1, 1, dat(32'h40));

        // outstanding limit, grant together with rvalid
        cyc(1, 1, 0, 0);
        chk("addr44", iaddr, 32'h44);
        cyc(1, 1, 0, 0);
        chk("addr48", iaddr, 32'h48);
        cyc(1, 1, 0, 0);
        chk("full_req0", {31'd0, ireq}, 0);
        cyc(1, 1, 1, 1, dat(32'h44));
        chk("full_req1", {31'd0, ireq}, 0);
        cyc(1, 1, 1, 1, dat(32'h48));
        chk("gnt_rv_addr", iaddr, 32'h4C);
        cyc(1, 1, 0, 0);
        chk("gnt_rv_req", {31'd0, ireq}, 1);
        chk("addr50", iaddr, 32'h50);
        cyc(1, 0, 0, 0);
        chk("full_req2", {31'd0, ireq}, 0);

        // error response forwarded, fetching continues
        cyc(1, 0, 1, 1, dat(32'h4C), 0, 0, 1);
        chk("err_valid", {31'd0, fvalid}, 1);
        cyc(1, 1, 0, 0);
        chk("err_next_req", {31'd0, ireq}, 1);
        chk("addr54", iaddr, 32'h54);

        // reset with two outstanding; late responses dropped
        cyc(0, 0, 0, 0);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 0, dat(32'h50));
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("late_rv0", {31'd0, fvalid}, 0);
        cyc(0, 0, 1, 0, dat(32'h54));
        chk("late_rv1", {31'd0, fvalid}, 0);
        cyc(0, 0, 0, 0);
        chk("sb_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
